// File: rtl/var_delay_checker.sv
// var_delay_checker
// ------------------------------------------------------------------------
// A bank of independent trigger/response delay checkers. Each channel opens
// a window when its trigger a[i] is sampled. A response c[i] inside the
// window [min, max] cycles after the trigger gives a pass pulse. A response
// that arrives before min gives fail_early. No response by max gives
// fail_tmo. A trigger that arrives while the window is open either gives
// fail_ovl (retrig_mode = 0) or restarts the window (retrig_mode = 1).
//
// All outputs are registered. A pulse is visible in the cycle after the
// edge that decided it. The two statistic counters are updated on that same
// edge, so a pulse and its effect on a counter appear together.
// ------------------------------------------------------------------------
module var_delay_checker #(
    parameter int NCH = 4,
    parameter int CW  = 8,
    parameter int SW  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           retrig_mode,
    input  logic [CW-1:0]  min_dly,
    input  logic [CW-1:0]  max_dly,
    input  logic [NCH-1:0] a,
    input  logic [NCH-1:0] c,
    input  logic           clr_cnt,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] pass,
    output logic [NCH-1:0] fail_early,
    output logic [NCH-1:0] fail_tmo,
    output logic [NCH-1:0] fail_ovl,
    output logic           cfg_err,
    output logic [SW-1:0]  pass_cnt,
    output logic [SW-1:0]  fail_cnt
);

    // Width needed to hold a popcount of NCH bits.
    localparam int PW = $clog2(NCH + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // ---------------------------------------------------------------------
    // Helper functions
    // ---------------------------------------------------------------------

    // Number of set bits in a channel vector.
    function automatic logic [PW-1:0] popcount(input logic [NCH-1:0] v);
        logic [PW-1:0] acc;
        acc = {PW{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            acc = acc + PW'(v[k]);
        end
        return acc;
    endfunction

    // Accumulator plus increment. The result sticks at all-ones instead of
    // wrapping back to zero.
    function automatic logic [SW-1:0] sat_add(input logic [SW-1:0] acc,
                                              input logic [PW-1:0] inc);
        logic [SW:0] sum;
        sum = {1'b0, acc} + (SW+1)'(inc);
        if (sum[SW]) begin
            return {SW{1'b1}};
        end else begin
            return sum[SW-1:0];
        end
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e          state_q [NCH];
    state_e          state_d [NCH];
    logic [CW-1:0]   cnt_q   [NCH];
    logic [CW-1:0]   cnt_d   [NCH];
    logic [CW-1:0]   min_q   [NCH];
    logic [CW-1:0]   min_d   [NCH];
    logic [CW-1:0]   max_q   [NCH];
    logic [CW-1:0]   max_d   [NCH];

    logic [NCH-1:0]  pass_q, pass_d;
    logic [NCH-1:0]  early_q, early_d;
    logic [NCH-1:0]  tmo_q, tmo_d;
    logic [NCH-1:0]  ovl_q, ovl_d;
    logic [NCH-1:0]  start_bad_s;
    logic [NCH-1:0]  start_good_s;
    logic            cfg_err_q, cfg_err_d;
    logic [SW-1:0]   pass_cnt_q, pass_cnt_d;
    logic [SW-1:0]   fail_cnt_q, fail_cnt_d;

    // A zero minimum is treated as one: a response on the trigger edge
    // itself can never count as a response to that trigger.
    logic [CW-1:0]   eff_min_s;
    logic            bounds_ok_s;

    // Compute the effective minimum and check the bound order on the
    // current inputs.
    always_comb begin
        if (min_dly == {CW{1'b0}}) begin
            eff_min_s = CW'(1'b1);
        end else begin
            eff_min_s = min_dly;
        end
        bounds_ok_s = (max_dly >= eff_min_s);
    end

    // Per-channel next state: resolve the open window, then start a new
    // window if a trigger is present.
    always_comb begin
        logic res_v;
        logic start_v;
        pass_d       = {NCH{1'b0}};
        early_d      = {NCH{1'b0}};
        tmo_d        = {NCH{1'b0}};
        ovl_d        = {NCH{1'b0}};
        start_bad_s  = {NCH{1'b0}};
        start_good_s = {NCH{1'b0}};
        res_v        = 1'b0;
        start_v      = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            min_d[i]   = min_q[i];
            max_d[i]   = max_q[i];
            res_v      = 1'b0;
            start_v    = 1'b0;
            if (!en) begin
                // When the checker is disabled, any open window is dropped
                // and no pulse is given for it.
                state_d[i] = ST_IDLE;
                cnt_d[i]   = {CW{1'b0}};
            end else begin
                case (state_q[i])
                    ST_WAIT: begin
                        if (c[i]) begin
                            if (cnt_q[i] < min_q[i]) begin
                                early_d[i] = 1'b1;
                            end else begin
                                pass_d[i] = 1'b1;
                            end
                            res_v = 1'b1;
                        end else if (cnt_q[i] == max_q[i]) begin
                            tmo_d[i] = 1'b1;
                            res_v    = 1'b1;
                        end else begin
                            res_v = 1'b0;
                        end

                        if (res_v) begin
                            // The window closes. A trigger on this same edge
                            // opens the next window and is not an overlap.
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = {CW{1'b0}};
                            start_v    = a[i];
                        end else if (a[i] && retrig_mode) begin
                            start_v = 1'b1;
                        end else begin
                            // cnt stays below max_q here, so it cannot wrap.
                            ovl_d[i] = a[i];
                            cnt_d[i] = cnt_q[i] + CW'(1'b1);
                        end
                    end
                    ST_IDLE: begin
                        // A response with no open window is ignored.
                        start_v = a[i];
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = {CW{1'b0}};
                    end
                endcase

                if (start_v) begin
                    if (bounds_ok_s) begin
                        state_d[i]      = ST_WAIT;
                        cnt_d[i]        = CW'(1'b1);
                        min_d[i]        = eff_min_s;
                        max_d[i]        = max_dly;
                        start_good_s[i] = 1'b1;
                    end else begin
                        state_d[i]      = ST_IDLE;
                        cnt_d[i]        = {CW{1'b0}};
                        start_bad_s[i]  = 1'b1;
                    end
                end else begin
                    start_good_s[i] = 1'b0;
                end
            end
        end
    end

    // cfg_err follows the most recent latch attempt and holds between
    // attempts. All channels share the same bound inputs, so the channels
    // that latch on one edge always agree on whether the bounds are valid.
    always_comb begin
        if (|start_bad_s) begin
            cfg_err_d = 1'b1;
        end else if (|start_good_s) begin
            cfg_err_d = 1'b0;
        end else begin
            cfg_err_d = cfg_err_q;
        end
    end

    // Statistic counters. They count the pulses being registered on this
    // edge. A clear wins over an increment in the same cycle.
    always_comb begin
        if (clr_cnt) begin
            pass_cnt_d = {SW{1'b0}};
            fail_cnt_d = {SW{1'b0}};
        end else begin
            pass_cnt_d = sat_add(pass_cnt_q, popcount(pass_d));
            fail_cnt_d = sat_add(fail_cnt_q, popcount(early_d | tmo_d | ovl_d));
        end
    end

    // Register all channel state, the pulses and the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= {CW{1'b0}};
                min_q[i]   <= {CW{1'b0}};
                max_q[i]   <= {CW{1'b0}};
            end
            pass_q     <= {NCH{1'b0}};
            early_q    <= {NCH{1'b0}};
            tmo_q      <= {NCH{1'b0}};
            ovl_q      <= {NCH{1'b0}};
            cfg_err_q  <= 1'b0;
            pass_cnt_q <= {SW{1'b0}};
            fail_cnt_q <= {SW{1'b0}};
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                min_q[i]   <= min_d[i];
                max_q[i]   <= max_d[i];
            end
            pass_q     <= pass_d;
            early_q    <= early_d;
            tmo_q      <= tmo_d;
            ovl_q      <= ovl_d;
            cfg_err_q  <= cfg_err_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    // Drive the output ports from the registers.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            busy[i] = (state_q[i] == ST_WAIT);
        end
        pass       = pass_q;
        fail_early = early_q;
        fail_tmo   = tmo_q;
        fail_ovl   = ovl_q;
        cfg_err    = cfg_err_q;
        pass_cnt   = pass_cnt_q;
        fail_cnt   = fail_cnt_q;
    end

endmodule

// File: doc/var_delay_checker.md
VAR_DELAY_CHECKER -- requirements
Module: var_delay_checker

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent trigger/response channels (1..32).
REQ-002 SHALL have parameter CW, default 8, width of delay bounds and per-channel cycle counter.
REQ-003 SHALL have parameter SW, default 16, width of pass/fail statistic counters.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port en  input  1  checker enable.
REQ-007 SHALL have port retrig_mode  input  1  0 = flag re-trigger as overlap, 1 = restart window.
REQ-008 SHALL have port min_dly  input  CW  earliest legal response delay in cycles.
REQ-009 SHALL have port max_dly  input  CW  latest legal response delay in cycles.
REQ-010 SHALL have port a  input  NCH  per-channel trigger.
REQ-011 SHALL have port c  input  NCH  per-channel response.
REQ-012 SHALL have port clr_cnt  input  1  synchronous clear of statistic counters.
REQ-013 SHALL have port busy  output  NCH  channel window open.
REQ-014 SHALL have port pass  output  NCH  one-cycle pulse, response within window.
REQ-015 SHALL have port fail_early  output  NCH  one-cycle pulse, response before min.
REQ-016 SHALL have port fail_tmo  output  NCH  one-cycle pulse, no response by max.
REQ-017 SHALL have port fail_ovl  output  NCH  one-cycle pulse, trigger while busy in mode 0.
REQ-018 SHALL have port cfg_err  output  1  registered: latched-at-sample bounds invalid (max_dly < effective min).
REQ-019 SHALL have ports pass_cnt, fail_cnt  output  SW each  saturating totals over all channels.

Function
REQ-020 Each channel SHALL be an IDLE/WAIT FSM with counter cnt; all outputs registered, pulses asserted in the cycle after the deciding edge.
REQ-021 IDLE, a[i]=1 sampled at edge E: go WAIT, cnt<=1, latch min_dly/max_dly into channel; response window = edges E+min..E+max.
REQ-022 Effective min SHALL be max(min_dly,1); if max_dly < effective min at latch, channel stays IDLE and cfg_err SHALL assert until next valid latch.
REQ-023 WAIT, c[i]=1: cnt < min -> fail_early; min <= cnt <= max -> pass; either way go IDLE.
REQ-024 WAIT, c[i]=0 and cnt == max -> fail_tmo, go IDLE; otherwise cnt<=cnt+1 (never wraps, max bounds it).
REQ-025 WAIT, a[i]=1 and no resolution this edge: mode 0 -> fail_ovl pulse, window unchanged; mode 1 -> cnt<=1, bounds re-latched, no pulse.
REQ-026 Resolution (c or timeout) and a[i]=1 on same edge: resolve pulse emitted AND new window starts (WAIT, cnt<=1); no fail_ovl.
REQ-027 IDLE, c[i]=1 without a[i]: ignored, no pulse.
REQ-028 Channels SHALL be fully independent; no shared state except statistic counters.
REQ-029 pass_cnt SHALL add popcount(pass) each cycle; fail_cnt SHALL add popcount(fail_early|fail_tmo|fail_ovl); both saturate at 2^SW-1.
REQ-030 clr_cnt=1 SHALL zero both counters that cycle, overriding same-cycle increments.
REQ-031 en=0 SHALL force all channels IDLE next edge, suppress all pulses, hold counters; an open window is discarded without fail.

Reset
REQ-032 rst_n=0 SHALL asynchronously clear all FSMs to IDLE, cnt, latched bounds, busy, all pulses, cfg_err, pass_cnt, fail_cnt to 0.
REQ-033 Reset mid-window SHALL discard the window with no pulse; first trigger is sampled on first rising edge with rst_n=1.

Verification
REQ-034 min=2,max=5, a[0] at edge 10, c[0] at edge 13 -> pass[0] one cycle after edge 13, pass_cnt=1.
REQ-035 min=2,max=5, a[1] at 10, c[1] at 11 -> fail_early[1]; a[1] at 20, no c -> fail_tmo[1] after edge 25, fail_cnt=2.
REQ-036 mode 0, a[2] at 10 and 12, c[2] at 14, min=1,max=8 -> fail_ovl at 12, pass at 14; mode 1 same stimulus with max=3 -> no fail_ovl, pass at 14 (cnt=2).
REQ-037 min=4,max=4, a[3] at 10, c[3] and a[3] at 14 -> pass at 14, busy[3] stays 1, new window expires fail_tmo at 18; min=6,max=3 -> cfg_err=1, busy=0.
REQ-038 All four channels pass same cycle with pass_cnt=2^SW-2 -> saturates at 2^SW-1; clr_cnt concurrent -> 0; rst_n low mid-window -> no pulse, all outputs 0.
